// File: rtl/dbp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbp_pkg : update-type encodings and BTB entry layout shared by dbp_btb/dbp_ras
// Rev 1.0
// ---------------------------------------------------------------------------
package dbp_pkg;

   // Entry fields are sized for the widest legal configuration; unused upper
   // bits are always written as zero and fold away in synthesis.
   localparam int c_TAG_MAX_W = 30;
   localparam int c_CNT_MAX_W = 4;

   typedef enum logic [1:0] {
      UPD_BRANCH = 2'd0,
      UPD_JUMP   = 2'd1,
      UPD_CALL   = 2'd2,
      UPD_RET    = 2'd3
   } upd_type_e;

   typedef struct packed {
      logic                   valid;
      logic [c_TAG_MAX_W-1:0] tag;
      logic [31:0]            target;
      upd_type_e              typ;
      logic [c_CNT_MAX_W-1:0] cnt;
   } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/dbp_ras.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbp_ras : circular return-address stack; push on full overwrites the oldest
// Rev 1.0
// ---------------------------------------------------------------------------
module dbp_ras
   import dbp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  logic [31:0] i_data,
   input  logic        i_pop,
   output logic [31:0] o_top,
   output logic        o_empty
);

   localparam int c_PW = $clog2(DEPTH);

   logic [31:0]   r_stack [DEPTH];
   logic [c_PW-1:0] r_ptr;
   logic [c_PW:0]   r_cnt;
   logic [c_PW-1:0] w_top_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
         r_cnt <= '0;
      end else if (i_push) begin
         r_ptr <= r_ptr + 1'b1;
         if (r_cnt != (c_PW+1)'(DEPTH))
            r_cnt <= r_cnt + 1'b1;
      end else if (i_pop && (r_cnt != '0)) begin
         r_ptr <= r_ptr - 1'b1;
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && i_push)
         r_stack[r_ptr] <= i_data;
   end

   assign w_top_idx = r_ptr - 1'b1;
   assign o_top     = r_stack[w_top_idx];
   assign o_empty   = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dbp_btb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbp_btb : direct-mapped BTB with saturating counters; return stack when DBP_BTB_RAS_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module dbp_btb
   import dbp_pkg::*;
#(
   parameter int AWIDTH    = 6,
   parameter int TAG_W     = 8,
   parameter int CNT_W     = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        pause,
   input  logic        lookup_req,
   input  logic [31:0] lookup_pc,
   output logic        pred_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic [1:0]  upd_type,
   input  logic [31:0] upd_pred_target,
   output logic        redirect,
   output logic [31:0] redirect_add
);

   localparam int c_N        = 1 << AWIDTH;
   localparam int c_CNT_MAX  = (1 << CNT_W) - 1;
   localparam int c_CNT_INIT = 1 << (CNT_W - 1);
   localparam int c_TAG_HI   = AWIDTH + TAG_W + 1;

   btb_entry_t  r_tab [c_N];
   logic        r_req;
   logic [31:0] r_pc;

   logic [AWIDTH-1:0] w_lk_idx, w_up_idx;
   btb_entry_t        w_lk_ent, w_up_ent, w_new;
   logic              w_lk_hit, w_up_hit, w_wr;
   logic [31:0]       w_lk_target, w_actual;
   upd_type_e         w_up_type;
   logic              w_unused;

   // Lookup path: table is read with the pc captured on the previous edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req <= 1'b0;
         r_pc  <= '0;
      end else begin
         if (!pause) begin
            r_req <= lookup_req;
            r_pc  <= lookup_pc;
         end
         if (clear)
            r_req <= 1'b0;
      end
   end

   assign w_lk_idx = r_pc[AWIDTH+1:2];
   assign w_lk_ent = r_tab[w_lk_idx];
   assign w_lk_hit = w_lk_ent.valid &&
                     (w_lk_ent.tag == c_TAG_MAX_W'(r_pc[c_TAG_HI:AWIDTH+2]));

   assign pred_valid  = r_req && !pause && w_lk_hit;
   assign pred_taken  = pred_valid && ((w_lk_ent.typ != UPD_BRANCH) || w_lk_ent.cnt[CNT_W-1]);
   assign pred_target = pred_valid ? w_lk_target : 32'd0;

   // Update path
   assign w_up_type = upd_type_e'(upd_type);
   assign w_up_idx  = upd_pc[AWIDTH+1:2];
   assign w_up_ent  = r_tab[w_up_idx];
   assign w_up_hit  = w_up_ent.valid &&
                      (w_up_ent.tag == c_TAG_MAX_W'(upd_pc[c_TAG_HI:AWIDTH+2]));

   always_comb begin
      w_new = w_up_ent;
      w_wr  = 1'b0;
      if (w_up_hit) begin
         w_wr         = 1'b1;
         w_new.target = upd_target;
         w_new.typ    = w_up_type;
         if (w_up_type == UPD_BRANCH) begin
            if (upd_taken && (w_up_ent.cnt != c_CNT_MAX_W'(c_CNT_MAX)))
               w_new.cnt = w_up_ent.cnt + 1'b1;
            else if (!upd_taken && (w_up_ent.cnt != '0))
               w_new.cnt = w_up_ent.cnt - 1'b1;
         end
      end else if (upd_taken || (w_up_type != UPD_BRANCH)) begin
         w_wr         = 1'b1;
         w_new.valid  = 1'b1;
         w_new.tag    = c_TAG_MAX_W'(upd_pc[c_TAG_HI:AWIDTH+2]);
         w_new.target = upd_target;
         w_new.typ    = w_up_type;
         w_new.cnt    = upd_taken ? c_CNT_MAX_W'(c_CNT_INIT) : c_CNT_MAX_W'(c_CNT_INIT - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < c_N; i++) begin
            r_tab[i].valid <= 1'b0;
            r_tab[i].cnt   <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < c_N; i++)
            r_tab[i].valid <= 1'b0;
      end else if (upd_valid && w_wr) begin
         r_tab[w_up_idx] <= w_new;
      end
   end

   assign w_actual     = upd_taken ? upd_target : (upd_pc + 32'd4);
   assign redirect     = upd_valid && (w_actual != upd_pred_target);
   assign redirect_add = redirect ? w_actual : 32'd0;

`ifdef DBP_BTB_RAS_EN
   logic [31:0] w_ras_top;
   logic        w_ras_empty;
   logic        w_upd_go;

   assign w_upd_go = upd_valid && !clear;

   dbp_ras #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_upd_go && (w_up_type == UPD_CALL)),
      .i_data  (upd_pc + 32'd4),
      .i_pop   (w_upd_go && (w_up_type == UPD_RET)),
      .o_top   (w_ras_top),
      .o_empty (w_ras_empty)
   );

   // An empty stack falls back to the target learned at the return site.
   assign w_lk_target = ((w_lk_ent.typ == UPD_RET) && !w_ras_empty) ? w_ras_top : w_lk_ent.target;
   assign w_unused    = ^{r_pc[31:c_TAG_HI+1], r_pc[1:0]};
`else
   assign w_lk_target = w_lk_ent.target;
   assign w_unused    = ^{r_pc[31:c_TAG_HI+1], r_pc[1:0], RAS_DEPTH[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbp_btb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dbp_btb : directed self-checking bench for dbp_btb (RAS section under DBP_BTB_RAS_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dbp_btb;

   localparam int AW = 8;   // keeps 0x100, 0x300 and 0x400 on distinct indices

   logic        clk = 1'b0;
   logic        reset, clear, pause, lookup_req;
   logic [31:0] lookup_pc;
   logic        pred_valid, pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid, upd_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic [1:0]  upd_type;
   logic        redirect;
   logic [31:0] redirect_add;

   int n_checks = 0;
   int n_errors = 0;
   logic        s_dir;
   logic [31:0] s_add;

   dbp_btb #(.AWIDTH(AW), .TAG_W(8), .CNT_W(2), .RAS_DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .clear(clear), .pause(pause),
      .lookup_req(lookup_req), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_type(upd_type), .upd_pred_target(upd_pred_target),
      .redirect(redirect), .redirect_add(redirect_add)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc);
      lookup_req = 1'b1;
      lookup_pc  = pc;
      tick();
      lookup_req = 1'b0;
   endtask

   task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [1:0] typ, input logic [31:0] pt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
      upd_target = tgt; upd_type = typ; upd_pred_target = pt;
      #1;
      s_dir = redirect;
      s_add = redirect_add;
      tick();
      upd_valid = 1'b0;
   endtask

   // Branch counter walk from the allocated value 2: NT NT NT T T T T NT NT
   logic       cw_tk [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
   logic       cw_pt [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic [31:0] pop_exp [5] = '{32'h202C, 32'h2024, 32'h201C, 32'h500, 32'h500};

   initial begin
      reset = 1'b1; clear = 1'b0; pause = 1'b0; lookup_req = 1'b0; lookup_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      upd_type = 2'd0; upd_pred_target = '0;
      tick(); tick(); tick();
      reset = 1'b0;

      lookup(32'h100);
      check("rst_pv", pred_valid, 0);
      check("rst_pt", pred_taken, 0);
      check("rst_redir", redirect, 0);

      update(32'h100, 1, 32'h200, 2'd0, 32'h104);
      check("mispredict_redir", s_dir, 1);
      check("mispredict_add", s_add, 32'h200);

      lookup(32'h100);
      check("hit_pv", pred_valid, 1);
      check("hit_pt", pred_taken, 1);
      check("hit_tgt", pred_target, 32'h200);

      for (int i = 0; i < 9; i++) begin
         update(32'h100, cw_tk[i], 32'h200, 2'd0, cw_tk[i] ? 32'h200 : 32'h104);
         if (i == 0) begin
            check("correct_redir", s_dir, 0);
            check("correct_add", s_add, 0);
         end
         lookup(32'h100);
         check($sformatf("ctr_step%0d_pt", i), pred_taken, cw_pt[i]);
      end
      // counter now 1: same-cycle update must not be visible to the live lookup
      lookup(32'h100);
      upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h280;
      upd_type = 2'd0; upd_pred_target = 32'h200;
      #1;
      check("preupd_tgt", pred_target, 32'h200);
      check("preupd_redir_add", redirect_add, 32'h280);
      tick();
      upd_valid = 1'b0;
      lookup(32'h100);
      check("postupd_tgt", pred_target, 32'h280);

      update(32'h600, 0, 32'h700, 2'd0, 32'h604);
      lookup(32'h600);
      check("nt_miss_noalloc", pred_valid, 0);

      lookup(32'h100 + (32'd1 << (AW + 2)));
      check("alias_pv", pred_valid, 0);

      lookup(32'h100);
      pause = 1'b1;
      #1;
      check("pause_mask", pred_valid, 0);
      lookup_pc = 32'h600;
      tick();
      pause = 1'b0;
      #1;
      check("pause_hold", pred_valid, 1);
      tick();

      update(32'h400, 1, 32'h500, 2'd3, 32'h500);
      lookup(32'h400);
      check("ret_pt", pred_taken, 1);
      check("ret_tgt", pred_target, 32'h500);

`ifdef DBP_BTB_RAS_EN
      update(32'h300, 1, 32'h800, 2'd2, 32'h800);
      lookup(32'h400);
      check("ras_top", pred_target, 32'h304);
      for (int i = 0; i < 5; i++)
         update(32'h2010 + 32'(i * 8), 1, 32'h3000, 2'd2, 32'h3000);
      lookup(32'h400);
      check("ras_full_top", pred_target, 32'h2034);
      for (int i = 0; i < 5; i++) begin
         update(32'h400, 1, 32'h500, 2'd3, 32'h500);
         lookup(32'h400);
         check($sformatf("ras_pop%0d", i), pred_target, pop_exp[i]);
      end
`endif

      clear = 1'b1;
      update(32'h900, 1, 32'hA00, 2'd1, 32'hA00);
      clear = 1'b0;
      lookup(32'h100);
      check("clear_pv", pred_valid, 0);
      lookup(32'h900);
      check("clear_upd_dropped", pred_valid, 0);

      update(32'h100, 0, 32'h240, 2'd1, 32'h100);
      check("jump_nt_redir_add", s_add, 32'h104);
      reset = 1'b1;
      update(32'hB00, 1, 32'hC00, 2'd1, 32'hC00);
      reset = 1'b0;
      lookup(32'hB00);
      check("rst_upd_dropped", pred_valid, 0);
      lookup(32'h100);
      check("rst_clears_entry", pred_valid, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dbp_btb.md
DBP_BTB -- requirements
Module: dbp_btb

Interface
REQ-001 SHALL have parameter AWIDTH, default 6, index bits (2^AWIDTH entries).
REQ-002 SHALL have parameter TAG_W, default 8, tag bits taken from pc[AWIDTH+TAG_W+1:AWIDTH+2].
REQ-003 SHALL have parameter CNT_W, default 2, saturating-counter width (range 1..4).
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-stack entries (power of two).
REQ-005 SHALL have ports: clk in 1 clock; reset in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: clear in 1 flush table; pause in 1 pipeline stall.
REQ-007 SHALL have ports: lookup_req in 1, lookup_pc in 32 fetch address.
REQ-008 SHALL have ports: pred_valid out 1, pred_taken out 1, pred_target out 32.
REQ-009 SHALL have ports: upd_valid in 1, upd_pc in 32, upd_taken in 1, upd_target in 32, upd_type in 2 (0 branch, 1 jump, 2 call, 3 ret), upd_pred_target in 32 (next pc actually fetched).
REQ-010 SHALL have ports: redirect out 1, redirect_add out 32.

Function
REQ-011 Storage SHALL be flops per entry: valid, tag, target[31:0], type[1:0], counter[CNT_W-1:0].
REQ-012 Lookup SHALL register lookup_req/lookup_pc when !pause; outputs the following cycle from the registered pc.
REQ-013 pred_valid SHALL be registered req & !pause & valid & tag match at registered index.
REQ-014 pred_taken SHALL be pred_valid & (type!=branch | counter MSB set); pred_target = stored target (RAS top for ret when REQ-024 applies).
REQ-015 Update SHALL write at upd_pc index on upd_valid, independent of pause.
REQ-016 Update hit (valid & tag match): target/type overwritten; branch counter +1 if taken, -1 if not, saturating at 0 and 2^CNT_W-1.
REQ-017 Update miss: allocate (overwrite) if upd_taken or type!=branch; counter init 2^(CNT_W-1) if taken, else 2^(CNT_W-1)-1; not-taken branch miss SHALL NOT allocate.
REQ-018 Actual next pc = upd_taken ? upd_target : upd_pc+4 (32-bit wrap).
REQ-019 redirect SHALL be combinational: upd_valid & (actual != upd_pred_target); redirect_add = actual, else 0.
REQ-020 Same-cycle lookup and update to same index: lookup SHALL see pre-update contents.
REQ-021 clear SHALL zero all valid bits and the registered req in one cycle; an update in the same cycle SHALL be discarded.

Reset
REQ-022 reset SHALL zero all valid bits, counters, registered req/pc, RAS pointer and count; pred_* and redirect outputs 0 next cycle.
REQ-023 Reset mid-update SHALL take priority; no entry written.

Configuration
REQ-024 With DBP_BTB_RAS_EN defined: update type call pushes upd_pc+4; ret pops; ret-type hit predicts RAS top; push on full wraps overwriting oldest; pop on empty leaves stack empty and ret uses stored target.
REQ-025 Without DBP_BTB_RAS_EN: no RAS logic; ret treated like jump using stored target.

Structure
REQ-026 Shared package dbp_pkg SHALL hold the upd_type encodings and the entry struct typedef.
REQ-027 RAS SHALL be sub-module dbp_ras (push, pop, top, empty), instantiated only under DBP_BTB_RAS_EN.

Verification
REQ-028 Reset, lookup 0x100 -> pred_valid=0, pred_taken=0, redirect=0.
REQ-029 Update branch pc 0x100 taken target 0x200, pred_target 0x104 -> redirect=1 add 0x200; later lookup 0x100 -> pred_valid=1, pred_taken=1, target 0x200 one cycle after.
REQ-030 Three not-taken updates to that entry (CNT_W=2) -> counter 0, pred_taken=0; four taken -> counter saturates at 3.
REQ-031 Aliasing pc 0x100 + 2^(AWIDTH+2) lookup -> tag mismatch, pred_valid=0; clear then lookup 0x100 -> pred_valid=0.
REQ-032 RAS on: call at 0x300 then ret entry at 0x400 lookup -> pred_target 0x304; RAS_DEPTH+1 calls then pops -> oldest lost, final pop uses stored target.
